// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path:
// opcodes, ALU control codes, FSM state encoding and datapath select values.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    ALU_R_TYPE = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SLTIU  = 3'd2,
    ALU_SUB    = 3'd3,
    ALU_LUI    = 3'd4,
    ALU_ORI    = 3'd5
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    SRC_B_RT      = 2'd0,
    SRC_B_FOUR    = 2'd1,
    SRC_B_IMM     = 2'd2,
    SRC_B_IMM_SH2 = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_ALUOUT = 2'd1,
    PC_SRC_JUMP   = 2'd2
  } pc_source_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational control-word decode: Moore outputs per state, plus the few
// handshake/flag-qualified enables in FETCH and BRANCH.
module ctrl_out_decode
  import cpu_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic            [3:0] state,
  input  logic       [OP_W-1:0] op,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  i_or_d,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_dst,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic            [1:0] alu_src_b,
  output logic            [2:0] alu_op,
  output logic            [1:0] pc_source
);

  state_t st;
  assign st = state_t'(state);

  always_comb begin
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RT;
    alu_op     = ALU_R_TYPE;
    pc_source  = PC_SRC_ALU;
    case (st)
      // PC+4 is computed every fetch cycle but only committed with the instruction word
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRC_B_IMM_SH2;
        alu_op    = ALU_ADD;
      end
      S_R_EXEC: alu_src_a = 1'b1;
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        case (op)
          OP_SLTIU: alu_op = ALU_SLTIU;
          OP_ORI:   alu_op = ALU_ORI;
          OP_LUI:   alu_op = ALU_LUI;
          default:  alu_op = ALU_ADD;
        endcase
      end
      S_I_WB: reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PC_SRC_ALUOUT;
        pc_write  = (op == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main multi-cycle control FSM: state register, opcode latch, sticky
// illegal-opcode trap and retired-instruction counter.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic  [OP_W-1:0] instr_op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             reg_write_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic       [1:0] alu_src_b_o,
  output logic       [2:0] alu_op_o,
  output logic       [1:0] pc_source_o,
  output logic             illegal_o,
  output logic       [3:0] state_o,
  output logic [CNT_W-1:0] retired_o
);

  state_t            state_reg, state_next;
  logic   [OP_W-1:0] op_reg;
  logic              illegal_reg;
  logic  [CNT_W-1:0] retired_reg;
  logic              retire;

  logic dec_pc_write, dec_mem_read, dec_mem_write, dec_ir_write, dec_reg_write;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    if (mem_ready_i) state_next = S_DECODE;
      S_DECODE: begin
        case (instr_op_i)
          OP_RTYPE:                           state_next = S_R_EXEC;
          OP_LW, OP_SW:                       state_next = S_MEM_ADDR;
          OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI:  state_next = S_I_EXEC;
          OP_BEQ, OP_BNE:                     state_next = S_BRANCH;
          OP_J:                               state_next = S_JUMP;
          default:                            state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_next = (op_reg == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready_i) state_next = S_MEM_WB;
      S_MEM_WR:   if (mem_ready_i) state_next = S_FETCH;
      S_R_EXEC:   state_next = S_R_WB;
      S_I_EXEC:   state_next = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_TRAP;
    endcase
  end

  // A store only retires once memory has accepted it
  always_comb begin
    retire = 1'b0;
    case (state_reg)
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_WR:                                   retire = mem_ready_i;
      default:                                    retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= S_FETCH;
      op_reg      <= '0;
      illegal_reg <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) op_reg <= instr_op_i;
      if (state_next == S_TRAP) illegal_reg <= 1'b1;
      if (retire) retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  ctrl_out_decode #(.OP_W(OP_W)) u_decode (
    .state      (state_reg),
    .op         (op_reg),
    .zero       (zero_i),
    .mem_ready  (mem_ready_i),
    .pc_write   (dec_pc_write),
    .i_or_d     (i_or_d_o),
    .mem_read   (dec_mem_read),
    .mem_write  (dec_mem_write),
    .ir_write   (dec_ir_write),
    .reg_dst    (reg_dst_o),
    .reg_write  (dec_reg_write),
    .mem_to_reg (mem_to_reg_o),
    .alu_src_a  (alu_src_a_o),
    .alu_src_b  (alu_src_b_o),
    .alu_op     (alu_op_o),
    .pc_source  (pc_source_o)
  );

  // Reset masks every side-effecting enable so an aborted instruction writes nothing
  assign pc_write_o  = dec_pc_write  & ~rst_i;
  assign mem_read_o  = dec_mem_read  & ~rst_i;
  assign mem_write_o = dec_mem_write & ~rst_i;
  assign ir_write_o  = dec_ir_write  & ~rst_i;
  assign reg_write_o = dec_reg_write & ~rst_i;

  assign illegal_o = illegal_reg;
  assign state_o   = state_reg;
  assign retired_o = retired_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vectors drive inputs and
// queue the expected control word; a negedge checker pops and compares.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [5:0] op = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic             pc_write, i_or_d, mem_read, mem_write, ir_write;
  logic             reg_dst, reg_write, mem_to_reg, alu_src_a;
  logic       [1:0] alu_src_b;
  logic       [2:0] alu_op;
  logic       [1:0] pc_source;
  logic             illegal;
  logic       [3:0] state;
  logic [CNT_W-1:0] retired;

  multicycle_ctrl #(.CNT_W(CNT_W), .OP_W(6)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .instr_op_i   (op),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .pc_write_o   (pc_write),
    .i_or_d_o     (i_or_d),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .reg_dst_o    (reg_dst),
    .reg_write_o  (reg_write),
    .mem_to_reg_o (mem_to_reg),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .pc_source_o  (pc_source),
    .illegal_o    (illegal),
    .state_o      (state),
    .retired_o    (retired)
  );

  // Control word: {pc_write,i_or_d,mem_read,mem_write,ir_write,reg_dst,reg_write,mem_to_reg,alu_src_a,alu_src_b,alu_op,pc_source}
  logic [15:0] act_ctrl;
  assign act_ctrl = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                     reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};

  localparam logic [15:0] C_FETCH_RDY  = {9'b101010000, 2'd1, 3'd1, 2'd0};
  localparam logic [15:0] C_FETCH_WAIT = {9'b001000000, 2'd1, 3'd1, 2'd0};
  localparam logic [15:0] C_FETCH_RST  = {9'b000000000, 2'd1, 3'd1, 2'd0};
  localparam logic [15:0] C_DECODE     = {9'b000000000, 2'd3, 3'd1, 2'd0};
  localparam logic [15:0] C_R_EXEC     = {9'b000000001, 2'd0, 3'd0, 2'd0};
  localparam logic [15:0] C_R_WB       = {9'b000001100, 2'd0, 3'd0, 2'd0};
  localparam logic [15:0] C_I_ADD      = {9'b000000001, 2'd2, 3'd1, 2'd0};
  localparam logic [15:0] C_I_SLTIU    = {9'b000000001, 2'd2, 3'd2, 2'd0};
  localparam logic [15:0] C_I_LUI      = {9'b000000001, 2'd2, 3'd4, 2'd0};
  localparam logic [15:0] C_I_ORI      = {9'b000000001, 2'd2, 3'd5, 2'd0};
  localparam logic [15:0] C_I_WB       = {9'b000000100, 2'd0, 3'd0, 2'd0};
  localparam logic [15:0] C_MEM_ADDR   = {9'b000000001, 2'd2, 3'd1, 2'd0};
  localparam logic [15:0] C_MEM_RD     = {9'b011000000, 2'd0, 3'd0, 2'd0};
  localparam logic [15:0] C_MEM_WB     = {9'b000000110, 2'd0, 3'd0, 2'd0};
  localparam logic [15:0] C_MEM_WR     = {9'b010100000, 2'd0, 3'd0, 2'd0};
  localparam logic [15:0] C_MEM_WR_RST = {9'b010000000, 2'd0, 3'd0, 2'd0};
  localparam logic [15:0] C_BR_TAKEN   = {9'b100000001, 2'd0, 3'd3, 2'd1};
  localparam logic [15:0] C_BR_NOT     = {9'b000000001, 2'd0, 3'd3, 2'd1};
  localparam logic [15:0] C_JUMP       = {9'b100000000, 2'd0, 3'd0, 2'd2};
  localparam logic [15:0] C_ZERO       = 16'h0000;

  // rzr = {rst, zero, mem_ready}
  typedef struct {
    logic  [2:0] rzr;
    logic  [5:0] op;
    logic  [3:0] st;
    logic [15:0] ctrl;
    logic  [3:0] ret;
    logic        ill;
  } vec_t;

  typedef struct {
    int          tag;
    logic  [3:0] st;
    logic [15:0] ctrl;
    logic  [3:0] ret;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tag_cnt  = 0;

  function automatic vec_t mkv(logic [2:0] rzr, logic [5:0] o, logic [3:0] s,
                               logic [15:0] c, logic [3:0] ret, logic il);
    vec_t v;
    v.rzr = rzr; v.op = o; v.st = s; v.ctrl = c; v.ret = ret; v.ill = il;
    return v;
  endfunction

  task automatic check(string name, int tag, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got 0x%04h, expected 0x%04h", name, tag, act, exp);
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = v.rzr[2];
    zero      = v.rzr[1];
    mem_ready = v.rzr[0];
    op        = v.op;
    e.tag = tag_cnt; e.st = v.st; e.ctrl = v.ctrl; e.ret = v.ret; e.ill = v.ill;
    exp_q.push_back(e);
    tag_cnt++;
  endtask

  task automatic step(logic [2:0] rzr, logic [5:0] o, logic [3:0] s,
                      logic [15:0] c, logic [3:0] ret, logic il);
    apply(mkv(rzr, o, s, c, ret, il));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      $display("vec %0d: state=%0d ctrl=0x%04h retired=%0d illegal=%0b",
               cur.tag, state, act_ctrl, retired, illegal);
      check("state",   cur.tag, {12'd0, state},   {12'd0, cur.st});
      check("ctrl",    cur.tag, act_ctrl,         cur.ctrl);
      check("retired", cur.tag, {12'd0, retired}, {12'd0, cur.ret});
      check("illegal", cur.tag, {15'd0, illegal}, {15'd0, cur.ill});
    end
  end

  initial begin
    // Reset, R-type, ori, sw with one wait, sltiu, lui, j
    tbl.push_back(mkv(3'b101, 6'h00, 4'd0,  C_FETCH_RST,  4'd0, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h00, 4'd0,  C_FETCH_RDY,  4'd0, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h00, 4'd1,  C_DECODE,     4'd0, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h3F, 4'd6,  C_R_EXEC,     4'd0, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h3F, 4'd7,  C_R_WB,       4'd0, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h0D, 4'd0,  C_FETCH_RDY,  4'd1, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h0D, 4'd1,  C_DECODE,     4'd1, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h00, 4'd8,  C_I_ORI,      4'd1, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h00, 4'd9,  C_I_WB,       4'd1, 1'b0));
    tbl.push_back(mkv(3'b000, 6'h00, 4'd0,  C_FETCH_WAIT, 4'd2, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h2B, 4'd0,  C_FETCH_RDY,  4'd2, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h2B, 4'd1,  C_DECODE,     4'd2, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h2B, 4'd2,  C_MEM_ADDR,   4'd2, 1'b0));
    tbl.push_back(mkv(3'b000, 6'h2B, 4'd5,  C_MEM_WR,     4'd2, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h2B, 4'd5,  C_MEM_WR,     4'd2, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h0B, 4'd0,  C_FETCH_RDY,  4'd3, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h0B, 4'd1,  C_DECODE,     4'd3, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h0B, 4'd8,  C_I_SLTIU,    4'd3, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h0B, 4'd9,  C_I_WB,       4'd3, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h0F, 4'd0,  C_FETCH_RDY,  4'd4, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h0F, 4'd1,  C_DECODE,     4'd4, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h0F, 4'd8,  C_I_LUI,      4'd4, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h0F, 4'd9,  C_I_WB,       4'd4, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h08, 4'd0,  C_FETCH_RDY,  4'd5, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h08, 4'd1,  C_DECODE,     4'd5, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h08, 4'd8,  C_I_ADD,      4'd5, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h08, 4'd9,  C_I_WB,       4'd5, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h02, 4'd0,  C_FETCH_RDY,  4'd6, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h02, 4'd1,  C_DECODE,     4'd6, 1'b0));
    tbl.push_back(mkv(3'b001, 6'h02, 4'd11, C_JUMP,       4'd6, 1'b0));
    tbl.push_back(mkv(3'b000, 6'h00, 4'd0,  C_FETCH_WAIT, 4'd7, 1'b0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // lw with three wait cycles in MEM_RD: 8 cycles FETCH..MEM_WB
    step(3'b001, 6'h23, 4'd0, C_FETCH_RDY, 4'd7, 1'b0);
    step(3'b001, 6'h23, 4'd1, C_DECODE,    4'd7, 1'b0);
    step(3'b001, 6'h23, 4'd2, C_MEM_ADDR,  4'd7, 1'b0);
    for (int i = 0; i < 3; i++) step(3'b000, 6'h23, 4'd3, C_MEM_RD, 4'd7, 1'b0);
    step(3'b001, 6'h23, 4'd3, C_MEM_RD,    4'd7, 1'b0);
    step(3'b001, 6'h00, 4'd4, C_MEM_WB,    4'd7, 1'b0);

    // beq taken, bne with zero=1 (not taken), bne with zero=0 (taken)
    step(3'b001, 6'h04, 4'd0,  C_FETCH_RDY, 4'd8,  1'b0);
    step(3'b011, 6'h04, 4'd1,  C_DECODE,    4'd8,  1'b0);
    step(3'b011, 6'h00, 4'd10, C_BR_TAKEN,  4'd8,  1'b0);
    step(3'b001, 6'h05, 4'd0,  C_FETCH_RDY, 4'd9,  1'b0);
    step(3'b011, 6'h05, 4'd1,  C_DECODE,    4'd9,  1'b0);
    step(3'b011, 6'h00, 4'd10, C_BR_NOT,    4'd9,  1'b0);
    step(3'b001, 6'h05, 4'd0,  C_FETCH_RDY, 4'd10, 1'b0);
    step(3'b001, 6'h05, 4'd1,  C_DECODE,    4'd10, 1'b0);
    step(3'b001, 6'h00, 4'd10, C_BR_TAKEN,  4'd10, 1'b0);

    // Illegal opcode: sticky TRAP ignoring inputs, cleared only by reset
    step(3'b001, 6'h3F, 4'd0, C_FETCH_RDY, 4'd11, 1'b0);
    step(3'b001, 6'h3F, 4'd1, C_DECODE,    4'd11, 1'b0);
    for (int i = 0; i < 10; i++)
      step({1'b0, i[0], 1'b1}, 6'(i * 7), 4'd15, C_ZERO, 4'd11, 1'b1);
    step(3'b101, 6'h00, 4'd15, C_ZERO, 4'd11, 1'b1);

    // 17 jumps from a cleared counter: retired wraps 15 -> 0
    step(3'b001, 6'h02, 4'd0, C_FETCH_RDY, 4'd0, 1'b0);
    for (int k = 0; k < 17; k++) begin
      step(3'b001, 6'h02, 4'd1,  C_DECODE, 4'(k % 16), 1'b0);
      step(3'b001, 6'h02, 4'd11, C_JUMP,   4'(k % 16), 1'b0);
      step(3'b001, (k == 16) ? 6'h2B : 6'h02, 4'd0, C_FETCH_RDY, 4'((k + 1) % 16), 1'b0);
    end

    // Reset while a store waits for memory: write dropped, counter cleared
    step(3'b001, 6'h2B, 4'd1, C_DECODE,     4'd1, 1'b0);
    step(3'b000, 6'h2B, 4'd2, C_MEM_ADDR,   4'd1, 1'b0);
    step(3'b000, 6'h2B, 4'd5, C_MEM_WR,     4'd1, 1'b0);
    step(3'b000, 6'h2B, 4'd5, C_MEM_WR,     4'd1, 1'b0);
    step(3'b100, 6'h2B, 4'd5, C_MEM_WR_RST, 4'd1, 1'b0);
    step(3'b000, 6'h00, 4'd0, C_FETCH_WAIT, 4'd0, 1'b0);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
